// File: rtl/game_sequencer.sv
// Whack-a-mole round controller: game timer, mole placement and hit/miss scoring.
// Drives the score latch select/binary_in pair so it clears, tracks, then freezes.
module game_sequencer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int GAME_SECS   = 30,
    parameter int MOLE_CYCLES = 75_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  btn,
    output logic [3:0]  mole,
    output logic [1:0]  select,
    output logic [31:0] score,
    output logic [7:0]  misses,
    output logic [7:0]  time_left,
    output logic        game_done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    state_t      state, state_d;
    logic [31:0] prescaler, prescaler_d;
    logic [31:0] mole_timer, mole_timer_d;
    logic [31:0] score_d;
    logic [7:0]  misses_d;
    logic [7:0]  time_left_d;
    logic [3:0]  mole_d;
    logic        game_done_d;
    logic [7:0]  lfsr, lfsr_d;
    logic [3:0]  btn_q;

    logic [3:0]  press;
    logic        hit;
    logic        miss;
    logic        tick;
    logic        timeout;
    logic [3:0]  mole_new;

    assign select   = state;
    assign press    = btn & ~btn_q;
    assign hit      = |(press & mole);
    assign miss     = |(press & ~mole);
    assign tick     = (prescaler == 32'(TICK_DIV - 1));
    assign timeout  = (mole_timer == 32'(MOLE_CYCLES - 1));
    assign mole_new = 4'b0001 << lfsr[1:0];
    assign lfsr_d   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

    always_comb begin
        state_d      = state;
        prescaler_d  = prescaler;
        mole_timer_d = mole_timer;
        score_d      = score;
        misses_d     = misses;
        time_left_d  = time_left;
        mole_d       = mole;
        game_done_d  = 1'b0;
        unique case (state)
            PLAY: begin
                prescaler_d  = tick ? 32'd0 : prescaler + 32'd1;
                mole_timer_d = timeout ? 32'd0 : mole_timer + 32'd1;
                if (timeout) begin
                    mole_d = mole_new;
                end
                if (hit) begin
                    if (score != 32'hFFFF_FFFF) begin
                        score_d = score + 32'd1;
                    end
                    mole_d       = mole_new;
                    mole_timer_d = 32'd0;
                end
                if (miss && misses != 8'hFF) begin
                    misses_d = misses + 8'd1;
                end
                // The final tick overrides any relocation from this cycle
                if (tick) begin
                    if (time_left == 8'd1) begin
                        state_d     = OVER;
                        mole_d      = 4'b0000;
                        time_left_d = 8'd0;
                        game_done_d = 1'b1;
                    end else begin
                        time_left_d = time_left - 8'd1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    state_d  = IDLE;
                    score_d  = 32'd0;
                    misses_d = 8'd0;
                end
            end
            default: begin
                if (start) begin
                    state_d      = PLAY;
                    score_d      = 32'd0;
                    misses_d     = 8'd0;
                    prescaler_d  = 32'd0;
                    mole_timer_d = 32'd0;
                    time_left_d  = 8'(GAME_SECS);
                    mole_d       = mole_new;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            prescaler  <= 32'd0;
            mole_timer <= 32'd0;
            score      <= 32'd0;
            misses     <= 8'd0;
            time_left  <= 8'd0;
            mole       <= 4'b0000;
            game_done  <= 1'b0;
            lfsr       <= 8'hA5;
            btn_q      <= 4'b0000;
        end else begin
            state      <= state_d;
            prescaler  <= prescaler_d;
            mole_timer <= mole_timer_d;
            score      <= score_d;
            misses     <= misses_d;
            time_left  <= time_left_d;
            mole       <= mole_d;
            game_done  <= game_done_d;
            lfsr       <= lfsr_d;
            btn_q      <= btn;
        end
    end

endmodule
